// File: rtl/phase_stepper_pkg.sv
// -----------------------------------------------------------------------------
// phase_pkg
// Shared definitions for the phase stepper and its panel-button front end:
//   - phase_e       : FSM state / phase encoding (PH_RR, PH_F, PH_WB; 3 illegal)
//   - DEF_*         : default parameter values (50 MHz board timing)
// -----------------------------------------------------------------------------
package phase_pkg;

    // Next phase to issue. The encoding doubles as the external phase output.
    typedef enum logic [1:0] {
        PH_RR  = 2'd0,
        PH_F   = 2'd1,
        PH_WB  = 2'd2,
        PH_BAD = 2'd3
    } phase_e;

    // 10 ms of stable level at 50 MHz.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    // Half-second auto-run advance at 50 MHz.
    localparam int DEF_AUTO_DIV        = 25000000;

endpackage : phase_pkg

// File: rtl/phase_stepper_if.sv
// -----------------------------------------------------------------------------
// phase_stepper_if
// Panel-side signal bundle of the phase stepper.
//   btn_step  : raw step button (asynchronous, bouncing, active-high)
//   auto_en   : 1 = auto-run, button ignored
//   wb_en     : gates the write-back strobe
//   stb_rr/stb_f/stb_wb : one-cycle phase strobes
//   phase     : next phase to issue (0 RR, 1 F, 2 WB)
//   busy      : instruction partially stepped
//   step_cnt  : completed-instruction count
// Handshake: there is no valid/ready pair here. Inputs are levels sampled every
// clock; each strobe is a single-cycle qualifier that the datapath must act on
// in the cycle it is high (no back-pressure exists).
// Modports: master = panel/stimulus side, slave = phase_stepper.
// -----------------------------------------------------------------------------
interface phase_stepper_if;
    logic       btn_step;
    logic       auto_en;
    logic       wb_en;
    logic       stb_rr;
    logic       stb_f;
    logic       stb_wb;
    logic [1:0] phase;
    logic       busy;
    logic [7:0] step_cnt;

    modport master (
        output btn_step, auto_en, wb_en,
        input  stb_rr, stb_f, stb_wb, phase, busy, step_cnt
    );

    modport slave (
        input  btn_step, auto_en, wb_en,
        output stb_rr, stb_f, stb_wb, phase, busy, step_cnt
    );
endinterface : phase_stepper_if

// File: rtl/phase_stepper_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronizes a raw push button, debounces it and emits a one-cycle pulse for
// every accepted rising level. Reusable for any panel button.
// Ports:
//   clk      : system clock
//   rst      : asynchronous, active-low reset
//   btn_i    : raw asynchronous button level
//   press_o  : registered one-cycle pulse per accepted press
// Parameter DEBOUNCE_CYCLES (>=1): consecutive cycles the synchronized level
// must differ from the accepted level before it is taken.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          db_dly_q;
    logic          press_q;

    // Debounce counter: any sample equal to the accepted level restarts the
    // qualification window, so only an unbroken run of differing samples wins.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_q;
            press_q  <= db_q & ~db_dly_q;
        end
    end

    assign press_o = press_q;

endmodule : btn_debounce

// File: rtl/phase_stepper.sv
// -----------------------------------------------------------------------------
// phase_stepper
// Turns a debounced step button, or an auto-run timer, into the RR -> F -> WB
// phase strobes that step one datapath instruction, and counts completed
// instructions.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : phase_stepper_if.slave (button/auto/wb_en in; strobes, phase, busy,
//          step_cnt out). All outputs are registered.
// Parameters: DEBOUNCE_CYCLES (>=1), AUTO_DIV (>=2).
// The FSM state register is driven straight out as bus.phase.
// -----------------------------------------------------------------------------
module phase_stepper
    import phase_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int AUTO_DIV        = DEF_AUTO_DIV
) (
    input  logic            clk,
    input  logic            rst,
    phase_stepper_if.slave  bus
);

    localparam int DW = $clog2(AUTO_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(AUTO_DIV - 1);

    logic          press;
    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic          advance;

    phase_e        state_q, state_d;
    logic          stb_rr_q, stb_rr_d;
    logic          stb_f_q,  stb_f_d;
    logic          stb_wb_q, stb_wb_d;
    logic          busy_q,   busy_d;
    logic [7:0]    cnt_q,    cnt_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.btn_step),
        .press_o (press)
    );

    // Auto divider: parked at 0 while disabled so a partial count never ticks
    // and the first tick after enabling always takes a full period.
    always_comb begin
        div_d = '0;
        if (bus.auto_en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    assign tick    = bus.auto_en & (div_q == DIV_LAST);
    // A button press during auto-run is dropped, never queued.
    assign advance = tick | (press & ~bus.auto_en);

    always_comb begin
        state_d  = state_q;
        stb_rr_d = 1'b0;
        stb_f_d  = 1'b0;
        stb_wb_d = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            PH_RR: begin
                if (advance) begin
                    stb_rr_d = 1'b1;
                    state_d  = PH_F;
                end
            end
            PH_F: begin
                if (advance) begin
                    stb_f_d = 1'b1;
                    state_d = PH_WB;
                end
            end
            PH_WB: begin
                if (advance) begin
                    // The instruction completes whether or not WB is enabled.
                    stb_wb_d = bus.wb_en;
                    cnt_d    = cnt_q + 8'd1;
                    state_d  = PH_RR;
                end
            end
            default: begin
                // Illegal encoding: recover silently.
                state_d = PH_RR;
            end
        endcase
        busy_d = (state_d != PH_RR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= '0;
            state_q  <= PH_RR;
            stb_rr_q <= 1'b0;
            stb_f_q  <= 1'b0;
            stb_wb_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            div_q    <= div_d;
            state_q  <= state_d;
            stb_rr_q <= stb_rr_d;
            stb_f_q  <= stb_f_d;
            stb_wb_q <= stb_wb_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.stb_rr   = stb_rr_q;
    assign bus.stb_f    = stb_f_q;
    assign bus.stb_wb   = stb_wb_q;
    assign bus.phase    = state_q;
    assign bus.busy     = busy_q;
    assign bus.step_cnt = cnt_q;

endmodule : phase_stepper

// File: tb/tb_phase_stepper.sv
// -----------------------------------------------------------------------------
// tb_phase_stepper
// Directed bench for phase_stepper with DEBOUNCE_CYCLES=4, AUTO_DIV=8.
// Strobe events are logged as cyc*4+code (code 1=RR, 2=F, 3=WB), where cyc is
// the number of rising edges since the current window started, and compared
// against a hand-built expected queue.
// -----------------------------------------------------------------------------
module tb_phase_stepper;

  localparam int DB = 4;
  localparam int AD = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_stepper_if bus();

  phase_stepper #(
    .DEBOUNCE_CYCLES (DB),
    .AUTO_DIV        (AD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_wb     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the rising edge, log any strobe.
  task automatic step();
    logic [31:0] n;
    logic [31:0] code;
    @(posedge clk);
    #1;
    cyc++;
    n = 32'(bus.stb_rr) + 32'(bus.stb_f) + 32'(bus.stb_wb);
    if (n != 0) begin
      check_val("one_strobe", n, 32'd1);
      code = bus.stb_rr ? 32'd1 : (bus.stb_f ? 32'd2 : 32'd3);
      obs_q.push_back(32'(cyc) * 4 + code);
      if (bus.stb_wb) n_wb++;
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic start_window();
    cyc = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_evt(input int c, input int code);
    exp_q.push_back(32'(c) * 4 + 32'(code));
  endtask

  task automatic compare_events(input string tag);
    int n;
    check_val({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_val({tag, "_evt"}, obs_q[i], exp_q[i]);
  endtask

  task automatic check_outs(input string tag, input int ph, input int bsy, input int cnt);
    check_val({tag, "_phase"}, 32'(bus.phase), 32'(ph));
    check_val({tag, "_busy"}, 32'(bus.busy), 32'(bsy));
    check_val({tag, "_cnt"}, 32'(bus.step_cnt), 32'(cnt));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b0;
    steps(5);
    rst = 1'b1;
  endtask

  // Clean press: strobe lands on the 8th edge of the 24-cycle window.
  task automatic press();
    bus.btn_step = 1'b1;
    steps(12);
    bus.btn_step = 1'b0;
    steps(12);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b0;
    bus.btn_step = 1'b0;
    bus.auto_en  = 1'b0;
    bus.wb_en    = 1'b1;

    // 1. reset
    steps(5);
    check_val("rst_strobes", {29'd0, bus.stb_rr, bus.stb_f, bus.stb_wb}, 32'd0);
    check_outs("rst_hold", 0, 0, 0);
    rst = 1'b1;
    steps(2);
    check_val("rst_rel_strobes", {29'd0, bus.stb_rr, bus.stb_f, bus.stb_wb}, 32'd0);
    check_outs("rst_rel", 0, 0, 0);

    // 2. clean press, then release
    start_window();
    bus.btn_step = 1'b1;
    steps(7);
    check_val("clean_pre", 32'(bus.stb_rr), 32'd0);
    step();
    check_val("clean_rr", 32'(bus.stb_rr), 32'd1);
    check_outs("clean_hi", 1, 1, 0);
    steps(12);
    bus.btn_step = 1'b0;
    steps(20);
    expect_evt(DB + 4, 1);
    compare_events("clean");
    check_outs("clean_end", 1, 1, 0);

    // 3. bounce then stable
    do_reset();
    start_window();
    for (int i = 0; i < 24; i++) begin
      bus.btn_step = ((i / 2) % 2 == 0);
      step();
    end
    bus.btn_step = 1'b1;
    steps(20);
    bus.btn_step = 1'b0;
    steps(12);
    expect_evt(32, 1);
    compare_events("bounce");

    // 4. full instruction with and without write-back
    do_reset();
    start_window();
    bus.wb_en = 1'b1;
    press(); press(); press();
    expect_evt(8, 1); expect_evt(32, 2); expect_evt(56, 3);
    compare_events("inst_wb");
    check_outs("inst_wb", 0, 0, 1);
    start_window();
    bus.wb_en = 1'b0;
    press(); press(); press();
    expect_evt(8, 1); expect_evt(32, 2);
    compare_events("inst_nowb");
    check_outs("inst_nowb", 0, 0, 2);

    // 5. auto mode with the button held (press at edge 9 must be dropped)
    start_window();
    bus.wb_en   = 1'b1;
    bus.auto_en = 1'b1;
    steps(2);
    bus.btn_step = 1'b1;
    steps(34);
    bus.auto_en = 1'b0;
    steps(20);
    bus.btn_step = 1'b0;
    steps(12);
    expect_evt(8, 1); expect_evt(16, 2); expect_evt(24, 3); expect_evt(32, 1);
    compare_events("auto");
    check_outs("auto_end", 1, 1, 3);

    // 6a. reset mid-instruction with a WB advance pending
    start_window();
    press();
    check_outs("pre_rst", 2, 1, 3);
    bus.btn_step = 1'b1;
    steps(7);
    #2;
    rst = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0);
    check_val("async_rst_wb", 32'(bus.stb_wb), 32'd0);
    steps(3);
    rst = 1'b1;
    bus.btn_step = 1'b0;
    steps(12);
    press();
    expect_evt(8, 2); expect_evt(54, 1);
    compare_events("midrst");
    check_outs("midrst_end", 1, 1, 0);

    // 6b. 256 auto instructions -> step_cnt wraps
    do_reset();
    start_window();
    n_wb        = 0;
    bus.wb_en   = 1'b1;
    bus.auto_en = 1'b1;
    steps(768 * AD - 1);
    check_outs("wrap_pre", 2, 1, 255);
    step();
    check_outs("wrap", 0, 0, 0);
    check_val("wrap_wb", 32'(bus.stb_wb), 32'd1);
    bus.auto_en = 1'b0;
    steps(16);
    check_val("wrap_nwb", 32'(n_wb), 32'd256);
    check_val("wrap_nevt", obs_q.size(), 32'd768);
    check_outs("wrap_end", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_phase_stepper
